// File: rtl/qspi_pkg.sv
// Shared types and constants for the QPI memory controller: FSM states, device
// command bytes and the write byte-enable decoder.
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_DATA,
    ST_CSHI
  } state_e;

  localparam logic [7:0] CMD_QREAD     = 8'hEB;
  localparam logic [7:0] CMD_QWRITE    = 8'h38;
  localparam logic [7:0] CMD_ENTER_QPI = 8'h35;

  typedef struct packed {
    logic       ok;
    logic [1:0] off;
    logic [2:0] len;
  } be_info_t;

  // Only runs of 1..4 adjacent lanes map onto a single device burst.
  function automatic be_info_t be_to_offset_len(input logic [3:0] be);
    be_info_t r;
    r.ok  = 1'b1;
    r.off = 2'd0;
    r.len = 3'd0;
    case (be)
      4'b0001: begin r.off = 2'd0; r.len = 3'd1; end
      4'b0010: begin r.off = 2'd1; r.len = 3'd1; end
      4'b0100: begin r.off = 2'd2; r.len = 3'd1; end
      4'b1000: begin r.off = 2'd3; r.len = 3'd1; end
      4'b0011: begin r.off = 2'd0; r.len = 3'd2; end
      4'b0110: begin r.off = 2'd1; r.len = 3'd2; end
      4'b1100: begin r.off = 2'd2; r.len = 3'd2; end
      4'b0111: begin r.off = 2'd0; r.len = 3'd3; end
      4'b1110: begin r.off = 2'd1; r.len = 3'd3; end
      4'b1111: begin r.off = 2'd0; r.len = 3'd4; end
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/qspi_clkgen.sv
// SCK divider: CLK_DIV clk cycles per half-period, with strobes marking the
// cycle in which SCK is about to rise or fall. Dropping en parks SCK low.
module qspi_clkgen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic ck_o,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ck_q, ck_d;
  logic          expire;

  assign expire   = en && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_stb = expire && !ck_q;
  assign fall_stb = expire && ck_q;
  assign ck_o     = ck_q;

  always_comb begin
    cnt_d = cnt_q;
    ck_d  = ck_q;
    if (!en) begin
      cnt_d = '0;
      ck_d  = 1'b0;
    end else if (expire) begin
      cnt_d = '0;
      ck_d  = ~ck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ck_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ck_q  <= ck_d;
    end
  end

endmodule

// File: rtl/qspi_mem_ctrl.sv
// QPI master turning single-word memory requests into APS6404-style frames:
// command, 24-bit address, optional dummy cycles, then 1..4 data bytes.
module qspi_mem_ctrl
  import qspi_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int CLK_DIV     = 1,
  parameter int RD_WAIT     = 6,
  parameter int CS_HIGH_MIN = 2,
  parameter bit INIT_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              qspi_ck_o,
  output logic              qspi_cs_o,
  output logic [3:0]        qspi_io_o,
  output logic [3:0]        qspi_io_oe,
  input  logic [3:0]        qspi_io_i
);

  state_e      state_q, state_d;
  logic        cs_q, cs_d, en_q, en_d, we_q, we_d;
  logic [3:0]  io_q, io_d, oe_q, oe_d;
  logic [63:0] sh_q, sh_d;
  logic [31:0] acc_q, acc_d, rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic        ready_q, ready_d, vld_q, vld_d, err_q, err_d;
  logic        rise_stb, fall_stb;

  be_info_t          chk;
  logic [ADDR_W-1:0] start_addr;
  logic [23:0]       addr24;
  logic [31:0]       wd_shift, wbytes;
  logic [7:0]        data_last;
  logic              unused_addr_lsb;

  qspi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk      (clk),
    .rst_n    (rst),
    .en       (en_q),
    .ck_o     (qspi_ck_o),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Write bytes are queued lowest enabled lane first, so they stream out in address order.
  assign chk        = be_to_offset_len(req_be);
  assign wd_shift   = req_wdata >> {chk.off, 3'b000};
  assign wbytes     = {wd_shift[7:0], wd_shift[15:8], wd_shift[23:16], wd_shift[31:24]};
  assign start_addr = req_we ? {req_addr[ADDR_W-1:2], chk.off} : {req_addr[ADDR_W-1:2], 2'b00};
  assign addr24     = 24'(start_addr);
  assign data_last  = {4'd0, len_q, 1'b0} - 8'd1;
  assign unused_addr_lsb = ^req_addr[1:0];

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    en_d    = en_q;
    we_d    = we_q;
    io_d    = io_q;
    oe_d    = oe_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ready_d = 1'b0;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      ST_INIT: begin
        if (!en_q) begin
          cs_d  = 1'b0;
          en_d  = 1'b1;
          sh_d  = {CMD_ENTER_QPI, 56'd0};
          io_d  = {3'b000, CMD_ENTER_QPI[7]};
          oe_d  = 4'b0001;
          cnt_d = '0;
        end else if (fall_stb) begin
          if (cnt_q == 8'd7) begin
            cs_d    = 1'b1;
            en_d    = 1'b0;
            io_d    = '0;
            oe_d    = '0;
            cnt_d   = '0;
            state_d = ST_CSHI;
          end else begin
            sh_d  = sh_q << 1;
            io_d  = {3'b000, sh_q[62]};
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          ready_d = 1'b0;
          if (req_we && !chk.ok) begin
            vld_d = 1'b1;
            err_d = 1'b1;
          end else begin
            we_d    = req_we;
            len_d   = req_we ? chk.len : 3'd4;
            sh_d    = {(req_we ? CMD_QWRITE : CMD_QREAD), addr24, wbytes};
            io_d    = req_we ? CMD_QWRITE[7:4] : CMD_QREAD[7:4];
            oe_d    = 4'hF;
            cs_d    = 1'b0;
            en_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (fall_stb) begin
          sh_d  = sh_q << 4;
          io_d  = sh_q[59:56];
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd1) begin
            cnt_d   = '0;
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (fall_stb) begin
          sh_d  = sh_q << 4;
          io_d  = sh_q[59:56];
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd5) begin
            cnt_d = '0;
            if (we_q) begin
              state_d = ST_DATA;
            end else begin
              io_d    = '0;
              oe_d    = '0;
              state_d = (RD_WAIT > 0) ? ST_WAIT : ST_DATA;
            end
          end
        end
      end
      ST_WAIT: begin
        if (fall_stb) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(RD_WAIT - 1)) begin
            cnt_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rise_stb && !we_q) begin
          acc_d = {acc_q[27:0], qspi_io_i};
        end
        if (fall_stb) begin
          if (cnt_q == data_last) begin
            cs_d    = 1'b1;
            en_d    = 1'b0;
            io_d    = '0;
            oe_d    = '0;
            cnt_d   = '0;
            vld_d   = 1'b1;
            rdata_d = we_q ? 32'd0 : {acc_q[7:0], acc_q[15:8], acc_q[23:16], acc_q[31:24]};
            state_d = ST_CSHI;
          end else begin
            sh_d  = sh_q << 4;
            io_d  = we_q ? sh_q[59:56] : 4'h0;
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_CSHI: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(CS_HIGH_MIN - 1)) begin
          cnt_d   = '0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT_EN ? ST_INIT : ST_IDLE;
      cs_q    <= 1'b1;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      io_q    <= '0;
      oe_q    <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      en_q    <= en_d;
      we_q    <= we_d;
      io_q    <= io_d;
      oe_q    <= oe_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ready_q <= ready_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = vld_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign qspi_cs_o  = cs_q;
  assign qspi_io_o  = io_q;
  assign qspi_io_oe = oe_q;

endmodule

// File: doc/qspi_mem_ctrl.md
Name: qspi_mem_ctrl

Overview:
- QSPI master that turns the MMU's single-word memory requests into QPI transactions on the external storage device (PSRAM/flash, APS6404-class command set).
- Sits directly downstream of the MMU's storage path.
- Drives split pin signals (out / output-enable / in); the MMU/pad level performs tristating onto external_qspi_pins.
- One outstanding request; the request/response handshake matches the core memory interface style.

Parameters:
- ADDR_W, 24, device byte-address width.
- CLK_DIV, 1, SCK half-period in clk cycles (>=1); one SCK cycle = 2*CLK_DIV clk.
- RD_WAIT, 6, dummy SCK cycles between address and read data.
- CS_HIGH_MIN, 2, minimum clk cycles cs_o stays high between transactions.
- INIT_EN, 1, send the Enter-QPI command (0x35, single-bit on io[0]) after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_addr  in  ADDR_W  byte address.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  4  byte enables (writes only).
- req_wdata  in  32  write data, little-endian lanes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data, valid with rsp_valid; 0 for writes.
- rsp_err  out  1  request rejected, valid with rsp_valid.
- qspi_ck_o  out  1  SCK.
- qspi_cs_o  out  1  chip select, active-low.
- qspi_io_o  out  4  data out.
- qspi_io_oe  out  4  per-pin output enable.
- qspi_io_i  in  4  data in.

Behaviour:
- Reset (async, immediate, including mid-transaction):
  - cs_o=1, ck_o=0, io_oe=0, io_o=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
  - Any transaction in flight is abandoned; no response is issued.
- States: INIT, IDLE, CMD, ADDR, WAIT, DATA, CSHI.
- INIT:
  - Entered when reset releases, if INIT_EN=1.
  - Sends 8 bits of 0x35, MSB first, on io[0] only (io_oe=4'b0001), then goes to CSHI.
  - If INIT_EN=0, go directly to IDLE.
- IDLE:
  - req_ready=1 only here.
  - On acceptance, latch all request fields.
- Write byte-enable check:
  - If req_we and req_be is zero or non-contiguous (not 1, 2, 3 or 4 adjacent lanes): rsp_valid=1 and rsp_err=1 in the next cycle; no bus activity; return to IDLE.
- Write start address and length:
  - Start address = {req_addr[ADDR_W-1:2], first-enabled-lane index}.
  - Byte count = number of enabled lanes.
- Reads:
  - Always fetch the full word at {req_addr[ADDR_W-1:2], 2'b00}; req_addr[1:0] is ignored.
- Frame (QPI, all 4 pins, high nibble of each byte first):
  - CMD: 2 SCK cycles, 0xEB for read, 0x38 for write.
  - ADDR: 6 SCK cycles, 24-bit address, MSB nibble first; upper bits are zero-filled if ADDR_W<24.
  - WAIT: RD_WAIT SCK cycles, reads only, io_oe=0.
  - DATA: 2 SCK cycles per byte. Writes drive io_o with io_oe=4'hF. Reads hold io_oe=0.
- Timing:
  - cs_o falls the cycle after acceptance, with ck_o=0 and the first nibble already driven.
  - io_o changes only while ck_o is low.
  - ck_o rises after CLK_DIV cycles and falls after a further CLK_DIV cycles.
  - io_i is sampled in the clk cycle in which ck_o is driven 0->1.
- Read assembly:
  - Byte k (k=0..3) goes to rsp_rdata[8k+7:8k].
  - The first nibble of each byte goes to bits [8k+7:8k+4].
- Completion:
  - After the last SCK low phase completes, cs_o=1, ck_o=0, io_oe=0.
  - rsp_valid pulses in that same cycle, with rsp_err=0.
  - Then enter CSHI.
- CSHI: hold cs_o high for CS_HIGH_MIN cycles (including the completion cycle), then go to IDLE.
- Latency (CLK_DIV=1, RD_WAIT=6, acceptance at cycle T):
  - Read: 22 SCK cycles, rsp_valid at T+45.
  - 4-byte write: rsp_valid at T+33.
  - 1-byte write: rsp_valid at T+21.
- Back-to-back requests: next req_ready is no earlier than T_rsp+CS_HIGH_MIN.
- req_valid held during INIT/CSHI: waits, no loss.

Decomposition:
- qspi_pkg:
  - state enum.
  - Command constants: CMD_QREAD=8'hEB, CMD_QWRITE=8'h38, CMD_ENTER_QPI=8'h35.
  - Function be_to_offset_len (returns start lane, byte count, valid flag).
- Sub-module qspi_clkgen:
  - Divider counter generating ck_o plus one-cycle rise_stb / fall_stb strobes.
  - Enabled by the FSM; a fresh enable starts in the low phase.

Test Plan:
- Reset release, INIT_EN=1: io[0] carries 0,0,1,1,0,1,0,1 on 8 rising edges, io_oe=4'b0001; req_ready=1 CS_HIGH_MIN cycles after cs_o rises.
- Read addr 0x000104, device model returns bytes 11,22,33,44: pins show EB, 000104, 6 dummy cycles; rsp_rdata=32'h44332211 at T+45; rsp_err=0.
- Write addr 0x000203, be=4'b1100, wdata=32'hAABBCCDD: frame 38, 000202, bytes BB then AA; rsp_valid at T+25.
- Write be=4'b0101: rsp_err=1 at T+1; cs_o never falls.
- Async reset asserted mid-ADDR of a read: cs_o=1, io_oe=0 in the same cycle; no rsp_valid; after release, INIT repeats, then a new read completes correctly.
- CLK_DIV=3, two back-to-back reads: ck_o period 6 clk; cs_o high for >=CS_HIGH_MIN cycles between frames; both responses are correct.
